// File: rtl/shift_framer_pkg.sv
// Shared constants and FSM state encoding for the shift-register word framer.
package shift_framer_pkg;

  localparam int unsigned WORD_W = 6;
  localparam int unsigned CNT_W  = 3;
  localparam logic [WORD_W-1:0] DEFAULT_PATTERN = 6'b101101;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COUNT   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry valid/ready word buffer with flush and drop-on-full indication.
module word_fifo2 #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  always_comb begin
    pop_ok  = pop && (count_q != 2'd0);
    drop    = push && (count_q == 2'd2) && !pop_ok;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !drop) begin
      if (pop_ok) begin
        // Simultaneous push/pop keeps occupancy; the head advances first.
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = din;
        end else begin
          head_d = din;
        end
      end else begin
        if (count_q == 2'd0) begin
          head_d = din;
        end else begin
          tail_d = din;
        end
        count_d = count_q + 2'd1;
      end
    end else if (pop_ok) begin
      head_d  = tail_q;
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign dout  = head_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/shift_word_framer.sv
// Frames 6-bit words out of a SIPO shift register and hands them to a 2-entry buffer.
// Optional pattern detector enabled by defining MATCH_DETECT_EN.
module shift_word_framer #(
  parameter int unsigned         WORD_W  = shift_framer_pkg::WORD_W,
  parameter logic [WORD_W-1:0]   PATTERN = shift_framer_pkg::DEFAULT_PATTERN
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              sync,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] q_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic              match
);
  import shift_framer_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             fifo_push;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  // sync outranks the capture push so a restart never leaks a stale word.
  assign fifo_push = (state_q == CAPTURE) && !sync;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (fifo_drop & fifo_full);
    if (sync) begin
      state_d    = COUNT;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          state_d = HUNT;
        end
        COUNT: begin
          if (shift_en) begin
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
              cnt_d   = '0;
              state_d = CAPTURE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        CAPTURE: begin
          state_d = COUNT;
          if (shift_en) begin
            cnt_d = CNT_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  word_fifo2 #(
    .W (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (clear),
    .flush (sync),
    .push  (fifo_push),
    .din   (q_in),
    .pop   (word_ready),
    .dout  (word_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign word_valid = !fifo_empty;
  assign overflow   = overflow_q;

`ifdef MATCH_DETECT_EN
  logic match_q, match_d;

  // Registered so the pulse lines up with the word appearing in the buffer.
  always_comb begin
    match_d = (state_q == CAPTURE) && !sync && (q_in == PATTERN);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`else
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_shift_word_framer.sv
// Scoreboard bench for shift_word_framer: a local shift-register model feeds q_in.
module tb_shift_word_framer;

  logic       clk = 1'b0;
  logic       clear;
  logic       sync;
  logic       shift_en;
  logic [5:0] q_in;
  logic [5:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic       overflow;
  logic       match;

  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] exp_q[$];
  logic [5:0] exp_w;

  always #5 clk = ~clk;

  shift_word_framer #(
    .WORD_W  (6),
    .PATTERN (6'b101101)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .sync       (sync),
    .shift_en   (shift_en),
    .q_in       (q_in),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .match      (match)
  );

  // Every accepted transfer must match the next expected word, in order.
  always @(negedge clk) begin
    if (clear === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_unexpected: word_out=%b transferred, required no transfer", word_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (word_out !== exp_w) begin
          miscompares++;
          $display("FAIL scoreboard_word: word_out=%b required=%b", word_out, exp_w);
        end
      end
    end
  end

  // One clock with optional shift; the upstream register loads on the same edge.
  task automatic step(input logic en, input logic b);
    shift_en = en;
    @(posedge clk);
    #1;
    shift_en = 1'b0;
    if (en) q_in = {q_in[4:0], b};
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic do_sync();
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic shift_word(input logic [5:0] w);
    for (int i = 5; i >= 0; i--) step(1'b1, w[i]);
  endtask

  task automatic test_reset();
    logic seen;
    clear = 1'b0; sync = 1'b0; shift_en = 1'b0; word_ready = 1'b0; q_in = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", word_valid); end
    vectors++; if (word_out !== 6'b0) begin miscompares++; $display("FAIL reset_word: got %b required 000000", word_out); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    vectors++; if (match !== 1'b0) begin miscompares++; $display("FAIL reset_match: got %b required 0", match); end
    clear = 1'b1;
    do_sync();
    shift_word(6'b110011);
    idle(1);
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL reset_prefill_valid: got %b required 1", word_valid); end
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    clear = 1'b0;
    #1;
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL reset_async_valid: got %b required 0", word_valid); end
    vectors++; if (word_out !== 6'b0) begin miscompares++; $display("FAIL reset_async_word: got %b required 000000", word_out); end
    @(posedge clk);
    #1;
    clear = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      if (word_valid !== 1'b0) seen = 1'b1;
    end
    idle(3);
    if (word_valid !== 1'b0) seen = 1'b1;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_hunt_no_word: word_valid seen=%b required 0", seen); end
  endtask

  task automatic test_basic();
    word_ready = 1'b1;
    do_sync();
    exp_q.push_back(6'b101101);
    shift_word(6'b101101);
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL basic_capture_cycle_valid: got %b required 0", word_valid); end
    idle(1);
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency_valid: got %b required 1", word_valid); end
    vectors++; if (word_out !== 6'b101101) begin miscompares++; $display("FAIL basic_word: got %b required 101101", word_out); end
    idle(1);
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL basic_one_cycle_valid: got %b required 0", word_valid); end
  endtask

  task automatic test_back_pressure();
    word_ready = 1'b0;
    do_sync();
    exp_q.push_back(6'b110001);
    exp_q.push_back(6'b011010);
    shift_word(6'b110001);
    shift_word(6'b011010);
    shift_word(6'b111100);
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL bp_overflow_early: got %b required 0", overflow); end
    idle(1);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow_set: got %b required 1", overflow); end
    vectors++; if (word_out !== 6'b110001) begin miscompares++; $display("FAIL bp_head_held: got %b required 110001", word_out); end
    idle(2);
    vectors++; if (word_out !== 6'b110001) begin miscompares++; $display("FAIL bp_head_stable: got %b required 110001", word_out); end
    word_ready = 1'b1;
    idle(2);
    idle(1);
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drained: word_valid got %b required 0", word_valid); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL bp_overflow_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_push_pop_full();
    do_sync();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ppf_sync_clears_overflow: got %b required 0", overflow); end
    word_ready = 1'b0;
    exp_q.push_back(6'b100110);
    exp_q.push_back(6'b001011);
    exp_q.push_back(6'b010101);
    shift_word(6'b100110);
    shift_word(6'b001011);
    shift_word(6'b010101);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ppf_no_overflow: got %b required 0", overflow); end
    vectors++; if (word_out !== 6'b001011) begin miscompares++; $display("FAIL ppf_head_after_pop: got %b required 001011", word_out); end
    word_ready = 1'b1;
    idle(3);
    vectors++; if (word_valid !== 1'b0) begin miscompares++; $display("FAIL ppf_drained: word_valid got %b required 0", word_valid); end
  endtask

  task automatic test_sync_mid_word();
    logic seen;
    word_ready = 1'b1;
    do_sync();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    do_sync();
    seen = 1'b0;
    step(1'b1, 1'b0); if (word_valid !== 1'b0) seen = 1'b1;
    step(1'b1, 1'b1); if (word_valid !== 1'b0) seen = 1'b1;
    step(1'b1, 1'b1); if (word_valid !== 1'b0) seen = 1'b1;
    step(1'b1, 1'b1); if (word_valid !== 1'b0) seen = 1'b1;
    step(1'b1, 1'b0); if (word_valid !== 1'b0) seen = 1'b1;
    idle(1);          if (word_valid !== 1'b0) seen = 1'b1;
    idle(1);          if (word_valid !== 1'b0) seen = 1'b1;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL sync_restart_early_word: word_valid seen=%b required 0", seen); end
    exp_q.push_back(6'b011101);
    step(1'b1, 1'b1);
    idle(1);
    vectors++; if (word_valid !== 1'b1) begin miscompares++; $display("FAIL sync_sixth_shift_valid: got %b required 1", word_valid); end
    vectors++; if (word_out !== 6'b011101) begin miscompares++; $display("FAIL sync_word: got %b required 011101", word_out); end
    idle(1);
  endtask

  task automatic test_match();
    int pulses;
    int exp_pulses;
`ifdef MATCH_DETECT_EN
    exp_pulses = 1;
`else
    exp_pulses = 0;
`endif
    pulses = 0;
    word_ready = 1'b1;
    do_sync();
    exp_q.push_back(6'b101101);
    exp_q.push_back(6'b000111);
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, 1'(6'b101101 >> i));
      if (match === 1'b1) pulses++;
    end
    idle(1);
    if (match === 1'b1) pulses++;
`ifdef MATCH_DETECT_EN
    vectors++; if (match !== 1'b1) begin miscompares++; $display("FAIL match_aligned: got %b required 1", match); end
`endif
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, 1'(6'b000111 >> i));
      if (match === 1'b1) pulses++;
    end
    idle(1);
    if (match === 1'b1) pulses++;
    idle(2);
    if (match === 1'b1) pulses++;
    vectors++; if (pulses !== exp_pulses) begin miscompares++; $display("FAIL match_pulse_count: got %0d required %0d", pulses, exp_pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_push_pop_full();
    test_sync_mid_word();
    test_match();
    idle(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d words outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
